// File: rtl/ptw_dmem_responder.sv
// rtl/ptw_dmem_responder.sv - memory-side responder serving PTE reads for the page-table walker
package ptw_dmem_pkg;

    localparam int unsigned PTW_ADDR_W = 64;

    typedef struct packed {
        logic                  valid;
        logic                  phys;
        logic [4:0]            cmd;
        logic [3:0]            typ;
        logic [PTW_ADDR_W-1:0] addr;
        logic                  kill;
        logic [63:0]           data;
    } ptw_dmem_req_t;

    typedef struct packed {
        ptw_dmem_req_t req;
    } ptw_dmem_comm_t;

    typedef struct packed {
        logic        valid;
        logic        nack;
        logic [63:0] data;
    } dmem_ptw_resp_t;

    typedef struct packed {
        logic           dmem_ready;
        dmem_ptw_resp_t resp;
    } dmem_ptw_comm_t;

endpackage

module ptw_dmem_responder
    import ptw_dmem_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = 40,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  ptw_dmem_comm_t         ptw_dmem_comm_i,
    output dmem_ptw_comm_t         dmem_ptw_comm_o,
    output logic                   mem_req_valid_o,
    output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                   mem_req_ready_i,
    input  logic                   mem_rsp_valid_i,
    input  logic [63:0]            mem_rsp_data_i,
    input  logic                   mem_rsp_error_i,
    output logic                   pmu_req_o,
    output logic                   pmu_nack_o
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [3:0] MT_D  = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_REQ  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_DRAIN    = 3'd3,
        S_RESP     = 3'd4,
        S_NACK     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PADDR_WIDTH-1:0] r_addr;
    logic [PADDR_WIDTH-1:0] r_last_addr;
    logic [RW-1:0]          r_retry;
    logic [63:0]            r_data;

    ptw_dmem_req_t          w_req;
    logic [PADDR_WIDTH-1:0] w_addr_ext;
    logic [PADDR_WIDTH-1:0] w_addr_aligned;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_rsp_err;
    logic                   w_retry_left;
    logic                   w_unused;

    assign w_req = ptw_dmem_comm_i.req;

    // Request address is zero-extended or truncated onto the physical port width
    if (PADDR_WIDTH <= PTW_ADDR_W) begin : g_addr_trunc
        assign w_addr_ext = w_req.addr[PADDR_WIDTH-1:0];
    end else begin : g_addr_ext
        assign w_addr_ext = {{(PADDR_WIDTH - PTW_ADDR_W){1'b0}}, w_req.addr};
    end

    assign w_addr_aligned = {w_addr_ext[PADDR_WIDTH-1:3], 3'b000};

    assign w_accept     = (r_state == S_IDLE) && w_req.valid && !w_req.kill;
    assign w_legal      = (w_req.cmd == M_XRD) && (w_req.typ == MT_D) && w_req.phys
                          && (w_req.addr[2:0] == 3'b000);
    assign w_rsp_err    = mem_rsp_valid_i && mem_rsp_error_i;
    assign w_retry_left = (r_retry < MAX_RETRY_C);

    // Write data is never used by a read-only responder
    assign w_unused = ^{w_req.data, w_req.addr};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? S_MEM_REQ : S_RESP;
                end
            end
            S_MEM_REQ: begin
                // Once memory has taken the request its response must still be drained
                if (mem_req_ready_i) begin
                    w_state_nxt = w_req.kill ? S_DRAIN : S_MEM_WAIT;
                end else if (w_req.kill) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (mem_rsp_valid_i) begin
                    w_state_nxt = (w_rsp_err && w_retry_left) ? S_NACK : S_RESP;
                end else if (w_req.kill) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_NACK:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_ptw_comm_o                 = '0;
        dmem_ptw_comm_o.dmem_ready      = (r_state == S_IDLE);
        dmem_ptw_comm_o.resp.valid      = (r_state == S_RESP);
        dmem_ptw_comm_o.resp.nack       = (r_state == S_NACK);
        dmem_ptw_comm_o.resp.data       = (r_state == S_RESP) ? r_data : 64'd0;
        mem_req_valid_o                 = (r_state == S_MEM_REQ);
        mem_req_addr_o                  = r_addr;
        pmu_req_o                       = w_accept;
        pmu_nack_o                      = (r_state == S_NACK);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr      <= '0;
            r_last_addr <= '0;
            r_retry     <= '0;
            r_data      <= '0;
        end else begin
            if (w_accept) begin
                // Zero data doubles as the V=0 PTE returned for illegal requests
                r_data <= '0;
                if (w_legal) begin
                    r_addr <= w_addr_aligned;
                    if (w_addr_aligned != r_last_addr) begin
                        r_retry <= '0;
                    end
                end
            end else if ((r_state == S_MEM_WAIT) && mem_rsp_valid_i) begin
                if (!w_rsp_err) begin
                    r_data  <= mem_rsp_data_i;
                    r_retry <= '0;
                end else if (w_retry_left) begin
                    r_retry     <= r_retry + 1'b1;
                    r_last_addr <= r_addr;
                end else begin
                    r_data  <= '0;
                    r_retry <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ptw_dmem_responder.sv
// tb/tb_ptw_dmem_responder.sv - directed self-checking bench for ptw_dmem_responder
module tb_ptw_dmem_responder;
    import ptw_dmem_pkg::*;

    logic           clk = 1'b0;
    logic           rstn;
    ptw_dmem_comm_t req_s;
    dmem_ptw_comm_t rsp_s;
    logic           mem_req_valid;
    logic [39:0]    mem_req_addr;
    logic           mem_req_ready;
    logic           mem_rsp_valid;
    logic [63:0]    mem_rsp_data;
    logic           mem_rsp_error;
    logic           pmu_req;
    logic           pmu_nack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ptw_dmem_responder #(
        .PADDR_WIDTH (40),
        .MAX_RETRY   (3)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .ptw_dmem_comm_i (req_s),
        .dmem_ptw_comm_o (rsp_s),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_ready_i (mem_req_ready),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_error_i (mem_rsp_error),
        .pmu_req_o       (pmu_req),
        .pmu_nack_o      (pmu_nack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] cmd, input logic [3:0] typ, input logic phys,
                             input logic [63:0] addr);
        req_s          = '0;
        req_s.req.valid = 1'b1;
        req_s.req.cmd  = cmd;
        req_s.req.typ  = typ;
        req_s.req.phys = phys;
        req_s.req.addr = addr;
        req_s.req.data = 64'hFFFF_0000_FFFF_0000;
    endtask

    task automatic legal_read(input string tag, input logic [63:0] addr, input int stall,
                              input logic err, input logic [63:0] data,
                              input logic exp_nack, input logic [63:0] exp_data);
        drive_req(5'b00000, 4'b0011, 1'b1, addr);
        mem_req_ready = 1'b0;
        @(negedge clk);
        check({tag, "_pmu_req"}, pmu_req, 1'b1);
        check({tag, "_rdy_T"}, rsp_s.dmem_ready, 1'b1);
        tick;
        req_s.req.valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, mem_req_valid, 1'b1);
            check({tag, "_stall_addr"}, mem_req_addr, addr);
            check({tag, "_stall_resp"}, rsp_s.resp.valid, 1'b0);
            tick;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check({tag, "_req_valid"}, mem_req_valid, 1'b1);
        check({tag, "_req_addr"}, mem_req_addr, addr);
        check({tag, "_rdy_req"}, rsp_s.dmem_ready, 1'b0);
        tick;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_error = err;
        mem_rsp_data  = data;
        @(negedge clk);
        check({tag, "_rdy_wait"}, rsp_s.dmem_ready, 1'b0);
        check({tag, "_early_resp"}, {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;
        mem_rsp_valid = 1'b0;
        mem_rsp_error = 1'b0;
        @(negedge clk);
        check({tag, "_resp_valid"}, rsp_s.resp.valid, !exp_nack);
        check({tag, "_resp_nack"}, rsp_s.resp.nack, exp_nack);
        check({tag, "_pmu_nack"}, pmu_nack, exp_nack);
        check({tag, "_resp_data"}, rsp_s.resp.data, exp_data);
        check({tag, "_rdy_resp"}, rsp_s.dmem_ready, 1'b0);
        tick;
        @(negedge clk);
        check({tag, "_rdy_after"}, rsp_s.dmem_ready, 1'b1);
        check({tag, "_quiet_after"}, {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;
    endtask

    task automatic illegal_read(input string tag, input logic [4:0] cmd, input logic [3:0] typ,
                                input logic [63:0] addr);
        drive_req(cmd, typ, 1'b1, addr);
        @(negedge clk);
        check({tag, "_pmu_req"}, pmu_req, 1'b1);
        check({tag, "_no_mem_T"}, mem_req_valid, 1'b0);
        tick;
        req_s.req.valid = 1'b0;
        @(negedge clk);
        check({tag, "_resp_valid"}, rsp_s.resp.valid, 1'b1);
        check({tag, "_resp_data"}, rsp_s.resp.data, 64'd0);
        check({tag, "_no_mem"}, mem_req_valid, 1'b0);
        tick;
        @(negedge clk);
        check({tag, "_rdy_after"}, rsp_s.dmem_ready, 1'b1);
        check({tag, "_quiet_after"}, {rsp_s.resp.valid, mem_req_valid}, 2'b00);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rstn          = 1'b0;
        req_s         = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rsp_s.dmem_ready, 1'b1);
        check("rst_valid_nack", {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        check("rst_data", rsp_s.resp.data, 64'd0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_addr", mem_req_addr, 64'd0);
        check("rst_pmu", {pmu_req, pmu_nack}, 2'b00);
        rstn = 1'b1;
        tick;

        // basic read and a stalled handshake
        legal_read("t1", 64'h0000_0000_8000_1008, 0, 1'b0, 64'h0000_0000_2000_0C01, 1'b0,
                   64'h0000_0000_2000_0C01);
        legal_read("t2", 64'h0000_0000_8000_1010, 5, 1'b0, 64'h0000_0000_2000_1C01, 1'b0,
                   64'h0000_0000_2000_1C01);

        // three nacks then data, then four errors ending in a zero PTE
        for (int i = 0; i < 3; i++) begin
            legal_read("t3_nack", 64'h0000_0000_8000_2000, 0, 1'b1, 64'hDEAD_BEEF, 1'b1, 64'd0);
        end
        legal_read("t3_ok", 64'h0000_0000_8000_2000, 0, 1'b0, 64'h0000_0000_2000_2C01, 1'b0,
                   64'h0000_0000_2000_2C01);
        for (int i = 0; i < 3; i++) begin
            legal_read("t3_nack2", 64'h0000_0000_8000_2000, 0, 1'b1, 64'hDEAD_BEEF, 1'b1, 64'd0);
        end
        legal_read("t3_zero", 64'h0000_0000_8000_2000, 0, 1'b1, 64'hDEAD_BEEF, 1'b0, 64'd0);

        // exhausted count on one address must not leak to a different address
        for (int i = 0; i < 3; i++) begin
            legal_read("t3_nackA", 64'h0000_0000_8000_2000, 0, 1'b1, 64'h1, 1'b1, 64'd0);
        end
        legal_read("t3_newaddr", 64'h0000_0000_8000_2008, 0, 1'b1, 64'h1, 1'b1, 64'd0);
        legal_read("t3_newok", 64'h0000_0000_8000_2008, 0, 1'b0, 64'h0000_0000_2000_3C01, 1'b0,
                   64'h0000_0000_2000_3C01);

        illegal_read("t4_cmd", 5'b01010, 4'b0011, 64'h0000_0000_8000_1000);
        illegal_read("t4_typ", 5'b00000, 4'b0010, 64'h0000_0000_8000_1000);
        illegal_read("t4_addr", 5'b00000, 4'b0011, 64'h0000_0000_8000_1004);

        // kill while waiting for memory: response arrives 4 cycles later and is drained
        drive_req(5'b00000, 4'b0011, 1'b1, 64'h0000_0000_8000_3000);
        @(negedge clk);
        check("t5_pmu_req", pmu_req, 1'b1);
        tick;
        req_s.req.valid = 1'b0;
        mem_req_ready   = 1'b1;
        @(negedge clk);
        check("t5_req_valid", mem_req_valid, 1'b1);
        tick;
        mem_req_ready  = 1'b0;
        req_s.req.kill = 1'b1;
        @(negedge clk);
        check("t5_kill_quiet", {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;
        req_s.req.kill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_drain_rdy", rsp_s.dmem_ready, 1'b0);
            check("t5_drain_quiet", {rsp_s.resp.valid, rsp_s.resp.nack, mem_req_valid}, 3'b000);
            tick;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0000_0000_0000_1234;
        @(negedge clk);
        check("t5_rsp_rdy", rsp_s.dmem_ready, 1'b0);
        check("t5_rsp_quiet", {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t5_rdy_back", rsp_s.dmem_ready, 1'b1);
        check("t5_no_resp", {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;

        // kill before the memory handshake
        drive_req(5'b00000, 4'b0011, 1'b1, 64'h0000_0000_8000_3100);
        @(negedge clk);
        tick;
        req_s.req.valid = 1'b0;
        req_s.req.kill  = 1'b1;
        @(negedge clk);
        check("t5b_req_valid", mem_req_valid, 1'b1);
        tick;
        req_s.req.kill = 1'b0;
        @(negedge clk);
        check("t5b_rdy", rsp_s.dmem_ready, 1'b1);
        check("t5b_quiet", {rsp_s.resp.valid, rsp_s.resp.nack, mem_req_valid}, 3'b000);
        tick;

        // response and kill together: the response wins
        drive_req(5'b00000, 4'b0011, 1'b1, 64'h0000_0000_8000_4000);
        @(negedge clk);
        tick;
        req_s.req.valid = 1'b0;
        mem_req_ready   = 1'b1;
        @(negedge clk);
        tick;
        mem_req_ready  = 1'b0;
        req_s.req.kill = 1'b1;
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 64'h0000_0000_3000_0C01;
        @(negedge clk);
        tick;
        req_s.req.kill = 1'b0;
        mem_rsp_valid  = 1'b0;
        @(negedge clk);
        check("t5c_valid", rsp_s.resp.valid, 1'b1);
        check("t5c_data", rsp_s.resp.data, 64'h0000_0000_3000_0C01);
        tick;

        // asynchronous reset during MEM_WAIT, then a stray response
        drive_req(5'b00000, 4'b0011, 1'b1, 64'h0000_0000_8000_5000);
        @(negedge clk);
        tick;
        req_s.req.valid = 1'b0;
        mem_req_ready   = 1'b1;
        @(negedge clk);
        tick;
        mem_req_ready = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rdy", rsp_s.dmem_ready, 1'b1);
        check("t6_quiet", {rsp_s.resp.valid, rsp_s.resp.nack, mem_req_valid, pmu_nack}, 4'b0000);
        check("t6_data", rsp_s.resp.data, 64'd0);
        check("t6_addr", mem_req_addr, 64'd0);
        @(posedge clk);
        #1;
        rstn          = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0000_0000_4000_0C01;
        @(negedge clk);
        check("t6_stray_rdy", rsp_s.dmem_ready, 1'b1);
        check("t6_stray_quiet", {rsp_s.resp.valid, rsp_s.resp.nack}, 2'b00);
        tick;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t6_after_rdy", rsp_s.dmem_ready, 1'b1);
        check("t6_after_quiet", {rsp_s.resp.valid, rsp_s.resp.nack, mem_req_valid}, 3'b000);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptw_dmem_responder.md
Name: ptw_dmem_responder

Overview:
- Memory-side responder for the page-table walker's dmem port.
- Accepts PTE read requests on the ptw_dmem_comm_t channel and issues single-beat 64-bit reads to a generic physical memory port.
- Returns PTE data, a nack, or a forced-invalid PTE back on dmem_ptw_comm_t.
- Sits between the PTW and the L2/memory interconnect; one outstanding request at a time.

Parameters:
PADDR_WIDTH, 40, physical address width on the memory port; the request address is zero-extended or truncated to this width.
MAX_RETRY, 3, number of consecutive nacks allowed for the same address; the next error returns a zero PTE.

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
ptw_dmem_comm_i  input  ptw_dmem_comm_t  fields req.valid, req.phys, req.cmd[4:0], req.typ[3:0], req.addr, req.kill, req.data[63:0]
dmem_ptw_comm_o  output  dmem_ptw_comm_t  fields dmem_ready, resp.valid, resp.nack, resp.data[63:0]
mem_req_valid_o  output  1  read request valid to memory
mem_req_addr_o  output  PADDR_WIDTH  8-byte-aligned physical read address
mem_req_ready_i  input  1  memory accepts request
mem_rsp_valid_i  input  1  memory response valid (single beat)
mem_rsp_data_i  input  64  read data
mem_rsp_error_i  input  1  retryable bus error, qualified by mem_rsp_valid_i
pmu_req_o  output  1  one-cycle pulse per accepted PTW request
pmu_nack_o  output  1  one-cycle pulse per nack issued

Behaviour:
- Reset values: state IDLE, dmem_ready=1, resp.valid=0, resp.nack=0, resp.data=0, mem_req_valid_o=0, mem_req_addr_o=0, retry count=0, last address=0, PMU pulses 0.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, DRAIN, RESP, NACK.
- dmem_ready=1 only in IDLE. The request is accepted when req.valid && dmem_ready && !req.kill. On accept: latch addr, drive pmu_req_o=1 that cycle.
- Legality check at accept. The request is legal only if all hold: cmd==5'b00000 (M_XRD), typ==4'b0011 (MT_D), phys==1, addr[2:0]==0.
  - Illegal request: go to RESP with resp.data=0, a V=0 PTE, so the walker faults. No memory access.
  - Legal request: go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o=1; mem_req_addr_o holds the latched address and is stable until the handshake.
  - mem_req_ready_i=1 -> MEM_WAIT.
  - req.kill=1 before the handshake -> IDLE with no response.
- MEM_WAIT: wait for mem_rsp_valid_i.
  - No error: register data, go to RESP, clear the retry count.
  - Error and retry count < MAX_RETRY: increment the retry count, go to NACK.
  - Error and retry count == MAX_RETRY: resp.data=0, go to RESP, clear the retry count.
  - req.kill=1 while waiting: go to DRAIN.
- DRAIN: discard the next mem_rsp_valid_i, then go to IDLE. No PTW response.
- RESP: resp.valid=1 for exactly one cycle with the registered data, then IDLE.
- NACK: resp.nack=1 and pmu_nack_o=1 for exactly one cycle, resp.valid=0, then IDLE.
- Retry count tracks the last nacked address. An accepted request whose address differs from the last address clears the count before use.
- Minimum latency:
  - Accept at cycle T; MEM_REQ at T+1 (ready same cycle); MEM_WAIT at T+2; rsp at T+2; RESP/NACK output at T+3.
  - Illegal request: RESP at T+1.
- resp.valid and resp.nack are never asserted together and are never asserted outside RESP/NACK.
- mem_rsp_valid_i in IDLE, MEM_REQ or RESP is ignored (protocol violation; no state change).
- mem_rsp_valid_i together with kill in MEM_WAIT: the response wins and goes to RESP or NACK; kill is ignored.
- req.data is unused (read-only responder).
- Reset mid-transaction: immediate return to IDLE. A memory response arriving after reset release in IDLE is ignored per the rule above.

Test Plan:
1. Legal read at addr 0x8000_1008, memory ready immediately and returns 0x0000_0000_2000_0C01 one cycle after the handshake -> resp.valid=1 at T+3 with that data; dmem_ready=0 during T+1..T+3; pmu_req_o pulse at T.
2. Memory holds mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o stays 1 with a constant address; response delayed by exactly 5 cycles.
3. Same address errors 3 times -> 3 nack pulses, each followed by dmem_ready=1. The PTW reissue returns data on the 4th try. With 4 consecutive errors, the 4th attempt returns resp.valid with data=0.
4. Illegal requests each give resp.valid at T+1 with data=0 and no mem_req_valid_o:
   - cmd=5'b01010
   - typ=4'b0010
   - addr=0x...1004
5. Kill in MEM_WAIT, then memory responds 4 cycles later -> no resp.valid/nack, DRAIN consumes the response, dmem_ready returns 1 the cycle after.
6. Assert rstn_i low during MEM_WAIT -> all outputs at reset values asynchronously; a stray mem_rsp_valid_i after release causes no response.
